game_deal_controller: RTL and testbench
=======================================

Name: game_deal_controller

Overview:
- Round sequencer for the two-player card game; owns the shared card source and deals alternately to the master and slave player accumulators.
- Requests a card, routes its value with a one-cycle ready pulse to exactly one player, waits for that player's total/finish to settle, then picks the next player.
- Ends the round when both players are done, and reports winner and per-player card counts.

Parameters:
- MAX_CARDS, 5, per-player card cap; reaching it marks that player done.
- INIT_CARDS, 2, cards dealt to each player before stand requests are honoured.

Ports:
- clock  in  1  system clock, rising edge.
- new_Game_n  in  1  asynchronous active-low reset; also the per-round clear.
- start  in  1  level/pulse; sampled in IDLE to begin a round.
- cardValid  in  1  card source has cardValue valid; single-cycle.
- cardValue  in  4  card value 1..11 from source.
- standMaster  in  1  level; master player requests no further cards.
- standSlave  in  1  level; slave player requests no further cards.
- finishMaster  in  1  master accumulator finish flag.
- finishSlave  in  1  slave accumulator finish flag.
- totalValueMaster  in  5  master running total.
- totalValueSlave  in  5  slave running total.
- cardReq  out  1  held high while awaiting a card.
- cardValueOut  out  4  registered card value routed to players.
- cardReadyMaster  out  1  one-cycle pulse: cardValueOut is for master.
- cardReadySlave  out  1  one-cycle pulse: cardValueOut is for slave.
- roundDone  out  1  high from DONE until reset.
- winner  out  2  00 none/in progress, 01 master, 10 slave, 11 tie.
- cardsMaster  out  3  cards dealt to master.
- cardsSlave  out  3  cards dealt to slave.

Behaviour:
- Reset (new_Game_n low, async): state IDLE; all outputs 0; turn pointer = master. Reset mid-round abandons the round with no further pulses.
- States: IDLE -> REQ -> GRANT -> SETTLE -> (REQ | DONE).
- IDLE: start=1 moves to REQ next edge.
- REQ: cardReq=1. On cardValid=1, latch cardValue into cardValueOut and move to GRANT. cardReq drops in the cycle after cardValid is seen. No timeout; the state waits indefinitely.
- GRANT: exactly one of cardReadyMaster/cardReadySlave is high for one cycle, selected by the turn pointer. Increment that player's card count (saturates at MAX_CARDS). Move to SETTLE.
- SETTLE: one cycle so the player register and finish flag update. Then compute:
  - doneM = finishMaster | cardsMaster==MAX_CARDS | (standMaster & cardsMaster>=INIT_CARDS).
  - doneS is the same expression using the slave signals.
  - Both done -> DONE. Otherwise toggle the turn pointer. If the other player is done, keep the current player. Then go to REQ.
- Initial deal order is M,S,M,S. Stand is ignored until a player holds INIT_CARDS cards.
- DONE: roundDone=1. winner is registered once on entry:
  - bust = total>21.
  - One bust -> the other player wins.
  - Both bust -> 11.
  - Otherwise the higher total wins; equal totals -> 11.
- DONE holds until reset; start is ignored.
- Latency: card accepted to ready pulse is 1 cycle; ready pulse to next cardReq is 2 cycles.
- cardReadyMaster and cardReadySlave are never high simultaneously. No pulse is issued to a done player.
- cardValid outside REQ is ignored (no pulse, no count).
- cardValue 0 is passed through unchanged; validity is the source's responsibility.

Decomposition:
- Shared package game_pkg holds:
  - state encoding (IDLE, REQ, GRANT, SETTLE, DONE);
  - winner codes (WIN_NONE, WIN_MASTER, WIN_SLAVE, WIN_TIE);
  - BUST_LIMIT=21.
- One natural sub-module: game_winner_judge, combinational compare of two 5-bit totals against BUST_LIMIT producing the 2-bit code. It is registered in this block on DONE entry.

Test Plan:
- Reset then start; source supplies 10,9,10,8 with both players standing after 2 cards, totals 20/17 -> pulse order M,S,M,S, then DONE, winner=01, cardsMaster=2, cardsSlave=2.
- Master finishes early (total 21 after 2 cards), slave keeps drawing 3,4,5 -> all later pulses go to slave only; DONE when finishSlave rises.
- Both players reach MAX_CARDS with no stand and no finish (cards of value 2) -> 10 pulses total, DONE, totals 10/10, winner=11.
- Master total 24 (bust), slave 18 -> winner=10; both bust (23/25) -> winner=11.
- cardValid asserted in SETTLE and in IDLE -> no ready pulse, counts unchanged. new_Game_n low during REQ -> cardReq=0, counts=0, state IDLE immediately (async).
- Stand asserted from cycle 0 -> still exactly INIT_CARDS cards dealt to each player before DONE.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and constants for the two-player card game.
// Holds the round sequencer state encoding, the winner codes and the bust limit.
// Imported by the deal controller and the winner judge.
package game_pkg;

    // Round sequencer states
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ    = 3'd1,
        GRANT  = 3'd2,
        SETTLE = 3'd3,
        DONE   = 3'd4
    } state_t;

    // Winner report codes
    typedef enum logic [1:0] {
        WIN_NONE   = 2'b00,
        WIN_MASTER = 2'b01,
        WIN_SLAVE  = 2'b10,
        WIN_TIE    = 2'b11
    } winner_t;

    // Totals strictly above this value are a bust
    localparam logic [4:0] BUST_LIMIT = 5'd21;

endpackage

// File: rtl/game_winner_judge.sv
// Purpose: combinational compare of the two player totals into a winner code.
// Latency: zero cycles (pure combinational), registered by the caller.
// Backpressure: none; output follows inputs continuously.
module game_winner_judge
    import game_pkg::*;
(
    input  logic [4:0] total_master,
    input  logic [4:0] total_slave,
    output logic [1:0] winner_code
);

    logic bust_m;
    logic bust_s;

    // Bust rules take priority, then the higher total wins, equal totals tie
    always_comb begin
        bust_m      = (total_master > BUST_LIMIT);
        bust_s      = (total_slave  > BUST_LIMIT);
        winner_code = WIN_TIE;
        if (bust_m && bust_s) begin
            winner_code = WIN_TIE;
        end else if (bust_m) begin
            winner_code = WIN_SLAVE;
        end else if (bust_s) begin
            winner_code = WIN_MASTER;
        end else if (total_master > total_slave) begin
            winner_code = WIN_MASTER;
        end else if (total_slave > total_master) begin
            winner_code = WIN_SLAVE;
        end else begin
            winner_code = WIN_TIE;
        end
    end

endmodule

// File: rtl/game_deal_controller.sv
// Purpose: round sequencer; requests cards and deals them alternately to master/slave, then judges the round.
// Latency: card accepted -> ready pulse 1 cycle; ready pulse -> next cardReq 2 cycles.
// Backpressure: waits indefinitely in REQ for cardValid; cardValid outside REQ is ignored.
module game_deal_controller
    import game_pkg::*;
#(
    parameter int MAX_CARDS  = 5,
    parameter int INIT_CARDS = 2
) (
    input  logic       clock,
    input  logic       new_Game_n,
    input  logic       start,
    input  logic       cardValid,
    input  logic [3:0] cardValue,
    input  logic       standMaster,
    input  logic       standSlave,
    input  logic       finishMaster,
    input  logic       finishSlave,
    input  logic [4:0] totalValueMaster,
    input  logic [4:0] totalValueSlave,
    output logic       cardReq,
    output logic [3:0] cardValueOut,
    output logic       cardReadyMaster,
    output logic       cardReadySlave,
    output logic       roundDone,
    output logic [1:0] winner,
    output logic [2:0] cardsMaster,
    output logic [2:0] cardsSlave
);

    localparam logic [2:0] MAX_C  = 3'(MAX_CARDS);
    localparam logic [2:0] INIT_C = 3'(INIT_CARDS);

    // Turn pointer: 0 = master, 1 = slave
    localparam logic TURN_M = 1'b0;
    localparam logic TURN_S = 1'b1;

    state_t     state_q,      state_d;
    logic       turn_q,       turn_d;
    logic       card_req_q,   card_req_d;
    logic [3:0] card_value_q, card_value_d;
    logic       ready_m_q,    ready_m_d;
    logic       ready_s_q,    ready_s_d;
    logic       round_done_q, round_done_d;
    logic [1:0] winner_q,     winner_d;
    logic [2:0] cards_m_q,    cards_m_d;
    logic [2:0] cards_s_q,    cards_s_d;

    logic       done_m;
    logic       done_s;
    logic [1:0] judged_winner;

    game_winner_judge u_judge (
        .total_master (totalValueMaster),
        .total_slave  (totalValueSlave),
        .winner_code  (judged_winner)
    );

    // A player stops drawing on finish, at the card cap, or on stand once the opening deal is complete
    always_comb begin
        done_m = finishMaster || (cards_m_q == MAX_C) || (standMaster && (cards_m_q >= INIT_C));
        done_s = finishSlave  || (cards_s_q == MAX_C) || (standSlave  && (cards_s_q >= INIT_C));
    end

    // Next-state and registered-output computation for the round sequencer
    always_comb begin
        state_d      = state_q;
        turn_d       = turn_q;
        card_req_d   = card_req_q;
        card_value_d = card_value_q;
        ready_m_d    = 1'b0;
        ready_s_d    = 1'b0;
        round_done_d = round_done_q;
        winner_d     = winner_q;
        cards_m_d    = cards_m_q;
        cards_s_d    = cards_s_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = REQ;
                    card_req_d = 1'b1;
                end
            end
            REQ: begin
                if (cardValid) begin
                    state_d      = GRANT;
                    card_req_d   = 1'b0;
                    card_value_d = cardValue;
                    ready_m_d    = (turn_q == TURN_M);
                    ready_s_d    = (turn_q == TURN_S);
                end
            end
            GRANT: begin
                // Count the card being handed over during this pulse cycle
                if (ready_m_q && (cards_m_q != MAX_C)) begin
                    cards_m_d = cards_m_q + 3'd1;
                end
                if (ready_s_q && (cards_s_q != MAX_C)) begin
                    cards_s_d = cards_s_q + 3'd1;
                end
                state_d = SETTLE;
            end
            SETTLE: begin
                if (done_m && done_s) begin
                    state_d      = DONE;
                    round_done_d = 1'b1;
                    winner_d     = judged_winner;
                end else begin
                    // Alternate turns, but never hand the turn to a player who is done
                    if (turn_q == TURN_M) begin
                        turn_d = done_s ? TURN_M : TURN_S;
                    end else begin
                        turn_d = done_m ? TURN_S : TURN_M;
                    end
                    state_d    = REQ;
                    card_req_d = 1'b1;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer state and registered outputs; new_Game_n clears everything and abandons any round
    always_ff @(posedge clock or negedge new_Game_n) begin
        if (!new_Game_n) begin
            state_q      <= IDLE;
            turn_q       <= TURN_M;
            card_req_q   <= 1'b0;
            card_value_q <= 4'd0;
            ready_m_q    <= 1'b0;
            ready_s_q    <= 1'b0;
            round_done_q <= 1'b0;
            winner_q     <= WIN_NONE;
            cards_m_q    <= 3'd0;
            cards_s_q    <= 3'd0;
        end else begin
            state_q      <= state_d;
            turn_q       <= turn_d;
            card_req_q   <= card_req_d;
            card_value_q <= card_value_d;
            ready_m_q    <= ready_m_d;
            ready_s_q    <= ready_s_d;
            round_done_q <= round_done_d;
            winner_q     <= winner_d;
            cards_m_q    <= cards_m_d;
            cards_s_q    <= cards_s_d;
        end
    end

    assign cardReq         = card_req_q;
    assign cardValueOut    = card_value_q;
    assign cardReadyMaster = ready_m_q;
    assign cardReadySlave  = ready_s_q;
    assign roundDone       = round_done_q;
    assign winner          = winner_q;
    assign cardsMaster     = cards_m_q;
    assign cardsSlave      = cards_s_q;

endmodule

// File: tb/tb_game_deal_controller.sv
// Bench for game_deal_controller: player accumulators, card source and a round-level reference model.
// Expected pulses and round results are queued by the model; a monitor pops and compares them.
// Directed rounds from the test plan are followed by randomized rounds and a mid-round reset.
module tb_game_deal_controller;

    logic       clock = 1'b0;
    logic       new_Game_n = 1'b0;
    logic       start = 1'b0;
    logic       cardValid = 1'b0;
    logic [3:0] cardValue = 4'd0;
    logic       standMaster, standSlave;
    logic       finishMaster, finishSlave;
    logic [4:0] totalValueMaster, totalValueSlave;
    logic       cardReq;
    logic [3:0] cardValueOut;
    logic       cardReadyMaster, cardReadySlave;
    logic       roundDone;
    logic [1:0] winner;
    logic [2:0] cardsMaster, cardsSlave;

    always #5 clock = ~clock;

    game_deal_controller #(.MAX_CARDS(5), .INIT_CARDS(2)) dut (
        .clock            (clock),
        .new_Game_n       (new_Game_n),
        .start            (start),
        .cardValid        (cardValid),
        .cardValue        (cardValue),
        .standMaster      (standMaster),
        .standSlave       (standSlave),
        .finishMaster     (finishMaster),
        .finishSlave      (finishSlave),
        .totalValueMaster (totalValueMaster),
        .totalValueSlave  (totalValueSlave),
        .cardReq          (cardReq),
        .cardValueOut     (cardValueOut),
        .cardReadyMaster  (cardReadyMaster),
        .cardReadySlave   (cardReadySlave),
        .roundDone        (roundDone),
        .winner           (winner),
        .cardsMaster      (cardsMaster),
        .cardsSlave       (cardsSlave)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int n_pulses = 0;

    int exp_pulse_q[$];   // (player << 4) | value, player 0 = master
    int exp_res_q[$];     // (winner << 6) | (cardsM << 3) | cardsS
    int src_q[$];         // cards the source will hand out
    int round_cards[$];   // card list of the current round

    // Player behaviour configuration for the current round
    int  tot_m = 0, tot_s = 0;
    bit  cfg_sa_m = 0, cfg_sa_s = 0;
    int  cfg_th_m = 31, cfg_th_s = 31;

    assign totalValueMaster = 5'(tot_m);
    assign totalValueSlave  = 5'(tot_s);
    assign finishMaster     = (tot_m >= 21);
    assign finishSlave      = (tot_s >= 21);
    assign standMaster      = cfg_sa_m | (tot_m >= cfg_th_m);
    assign standSlave       = cfg_sa_s | (tot_s >= cfg_th_s);

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Player accumulators: add the card on each ready pulse
    initial begin
        forever begin
            @(negedge clock);
            if (!new_Game_n) begin
                tot_m = 0;
                tot_s = 0;
            end else begin
                if (cardReadyMaster) tot_m = tot_m + int'(cardValueOut);
                if (cardReadySlave)  tot_s = tot_s + int'(cardValueOut);
            end
        end
    end

    // Card source: answers cardReq after a random delay, and fires stray cardValid while not requested
    initial begin
        forever begin
            @(negedge clock);
            cardValid = 1'b0;
            if (new_Game_n && cardReq && src_q.size() > 0) begin
                if ($urandom_range(0, 2) == 0) begin
                    cardValid = 1'b1;
                    cardValue = 4'(src_q.pop_front());
                end
            end else if (!cardReq && $urandom_range(0, 3) == 0) begin
                cardValid = 1'b1;
                cardValue = 4'($urandom_range(0, 15));
            end
        end
    end

    // Monitor: compares every ready pulse and every round completion against the queued expectations
    initial begin
        bit prev_done;
        int e;
        prev_done = 1'b0;
        forever begin
            @(negedge clock);
            if (cardReadyMaster || cardReadySlave) begin
                n_pulses++;
                check("ready_exclusive", 32'(cardReadyMaster & cardReadySlave), 0);
                check("pulse_expected", 32'(exp_pulse_q.size() > 0), 1);
                if (exp_pulse_q.size() > 0) begin
                    e = exp_pulse_q.pop_front();
                    check("pulse_player", 32'(cardReadySlave), 32'(e >> 4));
                    check("pulse_value", 32'(cardValueOut), 32'(e & 15));
                end
            end
            if (roundDone && !prev_done) begin
                check("done_expected", 32'(exp_res_q.size() > 0), 1);
                if (exp_res_q.size() > 0) begin
                    e = exp_res_q.pop_front();
                    check("winner", 32'(winner), 32'(e >> 6));
                    check("cards_master", 32'(cardsMaster), 32'((e >> 3) & 7));
                    check("cards_slave", 32'(cardsSlave), 32'(e & 7));
                    check("pulses_left_at_done", 32'(exp_pulse_q.size()), 0);
                end
            end
            prev_done = roundDone;
        end
    end

    // Round-level model: deal in turn, skip finished players, judge when both are done
    task automatic model_round(output int w, output int cm, output int cs);
        int  tm, ts, v;
        bit  turn, dm, ds, bm, bs;
        tm = 0; ts = 0; cm = 0; cs = 0; turn = 0;
        for (int i = 0; i < round_cards.size(); i++) begin
            v = round_cards[i];
            if (!turn) begin tm += v; cm++; end
            else       begin ts += v; cs++; end
            exp_pulse_q.push_back((int'(turn) << 4) | v);
            dm = (tm >= 21) || (cm == 5) || ((cfg_sa_m || tm >= cfg_th_m) && cm >= 2);
            ds = (ts >= 21) || (cs == 5) || ((cfg_sa_s || ts >= cfg_th_s) && cs >= 2);
            if (dm && ds) break;
            if (!turn) turn = ds ? 1'b0 : 1'b1;
            else       turn = dm ? 1'b1 : 1'b0;
        end
        bm = (tm > 21);
        bs = (ts > 21);
        if (bm && bs)      w = 3;
        else if (bm)       w = 2;
        else if (bs)       w = 1;
        else if (tm > ts)  w = 1;
        else if (ts > tm)  w = 2;
        else               w = 3;
        exp_res_q.push_back((w << 6) | (cm << 3) | cs);
    endtask

    task automatic do_reset();
        @(negedge clock);
        new_Game_n = 1'b0;
        src_q.delete();
        repeat (2) @(negedge clock);
        check("rst_cardReq", 32'(cardReq), 0);
        check("rst_cardValueOut", 32'(cardValueOut), 0);
        check("rst_readyM", 32'(cardReadyMaster), 0);
        check("rst_readyS", 32'(cardReadySlave), 0);
        check("rst_roundDone", 32'(roundDone), 0);
        check("rst_winner", 32'(winner), 0);
        check("rst_cardsM", 32'(cardsMaster), 0);
        check("rst_cardsS", 32'(cardsSlave), 0);
        new_Game_n = 1'b1;
    endtask

    task automatic run_round(input bit sa_m, input bit sa_s, input int th_m, input int th_s);
        int w, cm, cs, cyc, pulses_at_done;
        do_reset();
        cfg_sa_m = sa_m; cfg_sa_s = sa_s; cfg_th_m = th_m; cfg_th_s = th_s;
        model_round(w, cm, cs);
        src_q = round_cards;
        repeat ($urandom_range(2, 5)) @(negedge clock);   // stray cardValid in IDLE
        check("idle_no_count", 32'(cardsMaster + cardsSlave), 0);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        cyc = 0;
        while (!roundDone && cyc < 2000) begin
            @(negedge clock);
            cyc++;
        end
        check("round_completes", 32'(roundDone), 1);
        if (!roundDone) begin
            exp_pulse_q.delete();
            exp_res_q.delete();
        end else begin
            pulses_at_done = n_pulses;
            start = 1'b1;
            repeat (6) @(negedge clock);
            start = 1'b0;
            check("done_hold", 32'(roundDone), 1);
            check("done_winner_hold", 32'(winner), 32'(w));
            check("done_cardsM_hold", 32'(cardsMaster), 32'(cm));
            check("done_cardsS_hold", 32'(cardsSlave), 32'(cs));
            check("done_no_pulse", 32'(n_pulses), 32'(pulses_at_done));
        end
    endtask

    task automatic abort_round();
        int w, cm, cs, cyc, base;
        do_reset();
        cfg_sa_m = 0; cfg_sa_s = 0; cfg_th_m = 31; cfg_th_s = 31;
        round_cards = '{10, 9, 10, 8, 5, 5, 5, 5, 5, 5};
        model_round(w, cm, cs);
        src_q = round_cards;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        base = n_pulses;
        cyc = 0;
        while (n_pulses < base + 3 && cyc < 500) begin @(negedge clock); cyc++; end
        while (!cardReq && cyc < 500) begin @(negedge clock); cyc++; end
        check("abort_in_req", 32'(cardReq), 1);
        #2 new_Game_n = 1'b0;
        #1;
        check("abort_cardReq", 32'(cardReq), 0);
        check("abort_cardsM", 32'(cardsMaster), 0);
        check("abort_cardsS", 32'(cardsSlave), 0);
        check("abort_roundDone", 32'(roundDone), 0);
        exp_pulse_q.delete();
        exp_res_q.delete();
        src_q.delete();
        base = n_pulses;
        repeat (4) @(negedge clock);
        check("abort_no_pulse", 32'(n_pulses), 32'(base));
        new_Game_n = 1'b1;
    endtask

    initial begin
        // Both stand from the start: M,S,M,S then master wins 20/17
        round_cards = '{10, 9, 10, 8, 7, 7, 7, 7, 7, 7};
        run_round(1, 1, 31, 31);
        // Master finishes on 21 after two cards, slave keeps drawing to 21
        round_cards = '{10, 3, 11, 4, 5, 9, 2, 2, 2, 2};
        run_round(0, 0, 31, 31);
        // Card cap on both sides with value 2: ten pulses, tie 10/10
        round_cards = '{2, 2, 2, 2, 2, 2, 2, 2, 2, 2, 2, 2};
        run_round(0, 0, 31, 31);
        // Master busts at 24, slave stands on 18
        round_cards = '{10, 9, 4, 9, 10, 2, 2, 2, 2, 2};
        run_round(0, 0, 31, 17);
        // Both bust 23/25
        round_cards = '{10, 10, 10, 10, 3, 5, 2, 2, 2, 2};
        run_round(0, 0, 31, 31);
        // Reset in the middle of a round
        abort_round();
        // Randomized rounds
        for (int r = 0; r < 25; r++) begin
            round_cards.delete();
            for (int k = 0; k < 12; k++) round_cards.push_back(int'($urandom_range(1, 11)));
            run_round(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                      int'($urandom_range(12, 22)), int'($urandom_range(12, 22)));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
